// File: rtl/pl_intr_axil_slave_if.sv
// ---------------------------------------------------------------------------
// pl_intr_axil_slave_if
//   AXI4-Lite bus bundle between the PS interconnect (master) and the PL
//   interrupt controller (slave).
//
// Parameters:
//   C_S_AXI_ADDR_WIDTH  byte-address width of AW/AR
//   C_S_AXI_DATA_WIDTH  data width of W/R (only 32 is used)
//
// Signals (master view):
//   AW: S_AXI_AWADDR, S_AXI_AWVALID -> / <- S_AXI_AWREADY
//   W : S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID -> / <- S_AXI_WREADY
//   B : <- S_AXI_BRESP, S_AXI_BVALID / S_AXI_BREADY ->
//   AR: S_AXI_ARADDR, S_AXI_ARVALID -> / <- S_AXI_ARREADY
//   R : <- S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID / S_AXI_RREADY ->
// ---------------------------------------------------------------------------
interface pl_intr_axil_slave_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_S_AXI_DATA_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID, input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID, input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input  S_AXI_RREADY
    );
endinterface

// File: rtl/pl_intr_axil_slave.sv
// ---------------------------------------------------------------------------
// pl_intr_axil_slave
//   AXI4-Lite interrupt controller: collects C_NUM_OF_INTR PL interrupt
//   sources into ISR and drives one registered irq line to the PS.
//
//   Register map (word offset = ADDR[4:2]):
//     0x00 GIE  bit0 RW          0x04 IER  RW
//     0x08 ISR  RO               0x0C IAR  WO, write-1-to-clear ISR
//     0x10 IPR  RO = ISR & IER   0x14 ITR  WO software trigger (optional)
//     0x18/0x1C read 0, writes ignored
//
//   Optional feature: define PL_INTR_SWTRIG_EN to enable the ITR software
//   trigger at 0x14. Without it 0x14 behaves like an unused address.
//
// Ports:
//   ACLK     clock
//   ARESET   asynchronous active-high reset
//   s_axi    AXI4-Lite slave bundle (pl_intr_axil_slave_if.slave)
//   intr_in  raw interrupt sources, synchronous to ACLK
//   irq      interrupt to PS, polarity C_IRQ_ACTIVE_STATE
// ---------------------------------------------------------------------------
module pl_intr_axil_slave #(
    parameter int          C_S_AXI_DATA_WIDTH  = 32,
    parameter int          C_S_AXI_ADDR_WIDTH  = 5,
    parameter int          C_NUM_OF_INTR       = 1,
    parameter logic [31:0] C_INTR_SENSITIVITY  = 32'hFFFF_FFFF,
    parameter logic [31:0] C_INTR_ACTIVE_STATE = 32'hFFFF_FFFF,
    parameter bit          C_IRQ_ACTIVE_STATE  = 1'b1
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    pl_intr_axil_slave_if.slave      s_axi,
    input  logic [C_NUM_OF_INTR-1:0] intr_in,
    output logic                     irq
);

    localparam int N  = C_NUM_OF_INTR;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    // -----------------------------------------------------------------------
    // Write channel
    // -----------------------------------------------------------------------
    w_state_t          w_state_q, w_state_d;
    logic              aw_held_q, w_held_q;
    logic [2:0]        aw_word_q;
    logic [DW-1:0]     wdata_q;
    logic [3:0]        wstrb_q;

    logic              aw_hs, w_hs, wr_commit;
    logic [2:0]        wr_word;
    logic [31:0]       wr_data, wr_mask, wr_bits;
    logic [3:0]        wr_strb;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) w_state_q <= W_IDLE;
        else        w_state_q <= w_state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (wr_commit)          w_state_d = W_RESP;
            W_RESP:  if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
            default:                         w_state_d = W_IDLE;
        endcase
    end

    // Readies are held low while ARESET is asserted so the bus sees a quiet
    // slave during reset even though the state already sits in IDLE.
    always_comb begin
        s_axi.S_AXI_AWREADY = 1'b0;
        s_axi.S_AXI_WREADY  = 1'b0;
        s_axi.S_AXI_BVALID  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                s_axi.S_AXI_AWREADY = !aw_held_q && !ARESET;
                s_axi.S_AXI_WREADY  = !w_held_q  && !ARESET;
            end
            W_RESP:  s_axi.S_AXI_BVALID = 1'b1;
            default: ;
        endcase
    end

    assign s_axi.S_AXI_BRESP = 2'b00;

    assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;

    // Use the held copy if that half arrived earlier, else the live bus.
    assign wr_word   = aw_held_q ? aw_word_q : s_axi.S_AXI_AWADDR[4:2];
    assign wr_data   = w_held_q  ? wdata_q   : s_axi.S_AXI_WDATA;
    assign wr_strb   = w_held_q  ? wstrb_q   : s_axi.S_AXI_WSTRB;
    assign wr_commit = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_mask   = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    assign wr_bits   = wr_data & wr_mask;

    // NOTE: the holding registers are reset along with everything else;
    // they are few and a defined value avoids X on the first write.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_word_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            aw_held_q <= !wr_commit && (aw_held_q || aw_hs);
            w_held_q  <= !wr_commit && (w_held_q  || w_hs);
            if (aw_hs) aw_word_q <= s_axi.S_AXI_AWADDR[4:2];
            if (w_hs) begin
                wdata_q <= s_axi.S_AXI_WDATA;
                wstrb_q <= s_axi.S_AXI_WSTRB;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt registers
    // -----------------------------------------------------------------------
    logic          gie_q, gie_d;
    logic [N-1:0]  ier_q, ier_d;
    logic [N-1:0]  isr_q, isr_d;
    logic [N-1:0]  hist_q;
    logic          irq_q, irq_d;
    logic [N-1:0]  hw_evt, ack;
`ifdef PL_INTR_SWTRIG_EN
    logic [N-1:0]  sw_evt;
`endif

    // Edge sources compare against last cycle's input; level sources fire
    // every cycle the input sits at its active level.
    always_comb begin
        hw_evt = '0;
        for (int i = 0; i < N; i++) begin
            if (C_INTR_SENSITIVITY[i])
                hw_evt[i] = (intr_in[i] == C_INTR_ACTIVE_STATE[i]) &&
                            (hist_q[i]  != C_INTR_ACTIVE_STATE[i]);
            else
                hw_evt[i] = (intr_in[i] == C_INTR_ACTIVE_STATE[i]);
        end
    end

    always_comb begin
        gie_d = gie_q;
        ier_d = ier_q;
        ack   = '0;
`ifdef PL_INTR_SWTRIG_EN
        sw_evt = '0;
`endif
        if (wr_commit) begin
            case (wr_word)
                3'd0: if (wr_strb[0]) gie_d = wr_data[0];
                3'd1: ier_d = (ier_q & ~wr_mask[N-1:0]) | wr_bits[N-1:0];
                3'd3: ack   = wr_bits[N-1:0];
`ifdef PL_INTR_SWTRIG_EN
                3'd5: sw_evt = wr_bits[N-1:0];
`endif
                default: ;
            endcase
        end
        // A new event wins over a same-cycle acknowledge.
`ifdef PL_INTR_SWTRIG_EN
        isr_d = hw_evt | sw_evt | (isr_q & ~ack);
`else
        isr_d = hw_evt | (isr_q & ~ack);
`endif
        irq_d = gie_q && |(isr_q & ier_q);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            gie_q  <= 1'b0;
            ier_q  <= '0;
            isr_q  <= '0;
            hist_q <= ~C_INTR_ACTIVE_STATE[N-1:0];
            irq_q  <= 1'b0;
        end else begin
            gie_q  <= gie_d;
            ier_q  <= ier_d;
            isr_q  <= isr_d;
            hist_q <= intr_in;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;

    // -----------------------------------------------------------------------
    // Read channel
    // -----------------------------------------------------------------------
    r_state_t      r_state_q, r_state_d;
    logic [31:0]   rdata_q, rd_mux;
    logic          ar_hs;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state_q <= R_IDLE;
        else        r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs)              r_state_d = R_DATA;
            R_DATA:  if (s_axi.S_AXI_RREADY) r_state_d = R_IDLE;
            default:                         r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi.S_AXI_ARREADY = 1'b0;
        s_axi.S_AXI_RVALID  = 1'b0;
        case (r_state_q)
            R_IDLE:  s_axi.S_AXI_ARREADY = !ARESET;
            R_DATA:  s_axi.S_AXI_RVALID  = 1'b1;
            default: ;
        endcase
    end

    assign ar_hs             = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    assign s_axi.S_AXI_RDATA = rdata_q;
    assign s_axi.S_AXI_RRESP = 2'b00;

    // IAR, ITR and the unused offsets all read back as zero.
    always_comb begin
        rd_mux = '0;
        case (s_axi.S_AXI_ARADDR[4:2])
            3'd0:    rd_mux = {31'd0, gie_q};
            3'd1:    rd_mux = 32'(ier_q);
            3'd2:    rd_mux = 32'(isr_q);
            3'd4:    rd_mux = 32'(isr_q & ier_q);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)     rdata_q <= '0;
        else if (ar_hs) rdata_q <= rd_mux;
    end

    // Byte-lane address bits and mask bits above N carry no information.
    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0], wr_mask, wr_bits};

endmodule

// File: tb/tb_pl_intr_axil_slave.sv
// ---------------------------------------------------------------------------
// tb_pl_intr_axil_slave
//   Directed self-checking bench for pl_intr_axil_slave with default
//   parameters (one rising-edge source, active-high irq). Inputs change on
//   the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pl_intr_axil_slave;

    logic       clk = 1'b0;
    logic       ARESET;
    logic [0:0] intr_in;
    logic       irq;
    logic       irq_at_commit;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pl_intr_axil_slave_if #(.C_S_AXI_ADDR_WIDTH(5), .C_S_AXI_DATA_WIDTH(32)) axi ();

    pl_intr_axil_slave dut (
        .ACLK    (clk),
        .ARESET  (ARESET),
        .s_axi   (axi),
        .intr_in (intr_in),
        .irq     (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives AW and W together; optionally raises intr_in[0] so its edge
    // lands on the commit cycle. irq_at_commit is irq just after the commit.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit pulse);
        bit aw_done, w_done, aw_fire, w_fire, b_seen;
        aw_done = 1'b0;
        w_done  = 1'b0;
        b_seen  = 1'b0;
        @(negedge clk);
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = data;
        axi.S_AXI_WSTRB   = strb;
        axi.S_AXI_WVALID  = 1'b1;
        if (pulse) intr_in[0] = 1'b1;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            aw_fire = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
            w_fire  = axi.S_AXI_WVALID  && axi.S_AXI_WREADY;
            @(negedge clk);
            if (pulse) intr_in[0] = 1'b0;
            if (aw_fire) begin axi.S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_fire)  begin axi.S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
        end
        irq_at_commit = irq;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        for (int n = 0; n < 20; n++) begin
            if (axi.S_AXI_BVALID) begin
                b_seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!b_seen) begin
            check("wr_bvalid_timeout", 32'd0, 32'd1);
            return;
        end
        check("bresp", 32'(axi.S_AXI_BRESP), 32'd0);
        axi.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        axi.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        bit done;
        done = 1'b0;
        data = 32'hDEAD_BEEF;
        @(negedge clk);
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            if (axi.S_AXI_ARREADY) done = 1'b1;
            @(negedge clk);
        end
        axi.S_AXI_ARVALID = 1'b0;
        if (!done) begin
            check("rd_arready_timeout", 32'd0, 32'd1);
            return;
        end
        done = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (axi.S_AXI_RVALID) begin
                data = axi.S_AXI_RDATA;
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            check("rd_rvalid_timeout", 32'd0, 32'd1);
            return;
        end
        check("rresp", 32'(axi.S_AXI_RRESP), 32'd0);
        axi.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        axi.S_AXI_RREADY = 1'b0;
    endtask

    // One-cycle high pulse on intr_in[0]; returns two falling edges later,
    // after checking irq one edge after the capture.
    task automatic pulse_intr(input logic irq_exp_first, input logic irq_exp_second,
                              input string tag);
        @(negedge clk);
        intr_in[0] = 1'b1;
        @(negedge clk);
        intr_in[0] = 1'b0;
        check({tag, "_irq_c1"}, 32'(irq), 32'(irq_exp_first));
        @(negedge clk);
        check({tag, "_irq_c2"}, 32'(irq), 32'(irq_exp_second));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ARESET            = 1'b1;
        intr_in           = '0;
        irq_at_commit     = 1'b0;
        axi.S_AXI_AWADDR  = '0;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA   = '0;
        axi.S_AXI_WSTRB   = '0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_ARADDR  = '0;
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
        check("rst_arready", 32'(axi.S_AXI_ARREADY), 32'd0);
        check("rst_bvalid",  32'(axi.S_AXI_BVALID),  32'd0);
        check("rst_rvalid",  32'(axi.S_AXI_RVALID),  32'd0);
        check("rst_rdata",   axi.S_AXI_RDATA,        32'd0);
        check("rst_irq",     32'(irq),               32'd0);
        ARESET = 1'b0;
        axi_read(5'h00, rd); check("rst_gie", rd, 32'd0);
        axi_read(5'h04, rd); check("rst_ier", rd, 32'd0);
        axi_read(5'h08, rd); check("rst_isr", rd, 32'd0);
        axi_read(5'h10, rd); check("rst_ipr", rd, 32'd0);

        // Enable and take one edge interrupt: irq two edges after the pulse
        axi_write(5'h00, 32'h1, 4'hF, 1'b0);
        axi_write(5'h04, 32'h1, 4'hF, 1'b0);
        pulse_intr(1'b0, 1'b1, "edge1");
        axi_read(5'h10, rd); check("edge1_ipr", rd, 32'h1);
        axi_read(5'h08, rd); check("edge1_isr", rd, 32'h1);

        // Acknowledge: irq still high right after commit, low one edge later
        axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
        check("ack_irq_at_commit", 32'(irq_at_commit), 32'd1);
        check("ack_irq_after",     32'(irq),           32'd0);
        axi_read(5'h10, rd); check("ack_ipr", rd, 32'h0);
        axi_read(5'h0C, rd); check("iar_reads_zero", rd, 32'h0);

        // Masked source still captured; enabling it raises irq one edge later
        axi_write(5'h04, 32'h0, 4'hF, 1'b0);
        pulse_intr(1'b0, 1'b0, "masked");
        axi_read(5'h08, rd); check("masked_isr", rd, 32'h1);
        axi_read(5'h10, rd); check("masked_ipr", rd, 32'h0);
        check("masked_irq", 32'(irq), 32'd0);
        axi_write(5'h04, 32'h1, 4'hF, 1'b0);
        check("ier_irq_at_commit", 32'(irq_at_commit), 32'd0);
        check("ier_irq_after",     32'(irq),           32'd1);

        // Ack and new edge in the same cycle: set wins
        axi_write(5'h0C, 32'h1, 4'hF, 1'b1);
        check("race_irq_at_commit", 32'(irq_at_commit), 32'd1);
        check("race_irq_after",     32'(irq),           32'd1);
        axi_read(5'h08, rd); check("race_isr", rd, 32'h1);

        // W three cycles ahead of AW: IER <= 0, exactly one response
        @(negedge clk);
        axi.S_AXI_WDATA  = 32'h0;
        axi.S_AXI_WSTRB  = 4'hF;
        axi.S_AXI_WVALID = 1'b1;
        check("wfirst_wready", 32'(axi.S_AXI_WREADY), 32'd1);
        @(negedge clk);
        axi.S_AXI_WVALID = 1'b0;
        check("wfirst_wready_low", 32'(axi.S_AXI_WREADY), 32'd0);
        check("wfirst_awready",    32'(axi.S_AXI_AWREADY), 32'd1);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            check("wfirst_no_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
        end
        axi.S_AXI_AWADDR  = 5'h04;
        axi.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0;
        check("wfirst_bvalid",   32'(axi.S_AXI_BVALID), 32'd1);
        check("wfirst_bresp",    32'(axi.S_AXI_BRESP),  32'd0);
        @(negedge clk);
        check("wfirst_bvalid_hold", 32'(axi.S_AXI_BVALID),  32'd1);
        check("wfirst_awready_resp", 32'(axi.S_AXI_AWREADY), 32'd0);
        axi.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        axi.S_AXI_BREADY = 1'b0;
        check("wfirst_bvalid_done", 32'(axi.S_AXI_BVALID), 32'd0);
        @(negedge clk);
        check("wfirst_single_b", 32'(axi.S_AXI_BVALID), 32'd0);
        check("wfirst_irq", 32'(irq), 32'd0);
        axi_read(5'h04, rd); check("wfirst_ier", rd, 32'h0);

        // Bits above C_NUM_OF_INTR read zero
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, 1'b0);
        axi_read(5'h04, rd); check("ier_upper_zero", rd, 32'h1);
        check("ier_restore_irq", 32'(irq), 32'd1);

        // Strobe without byte 0 leaves GIE alone
        axi_write(5'h00, 32'h0, 4'hE, 1'b0);
        axi_read(5'h00, rd); check("gie_strb", rd, 32'h1);
        check("gie_strb_irq", 32'(irq), 32'd1);

        // Unused offsets
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, 1'b0);
        axi_read(5'h18, rd); check("rd_0x18", rd, 32'h0);
        axi_read(5'h1C, rd); check("rd_0x1c", rd, 32'h0);

        // Software trigger
        axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
        axi_read(5'h08, rd); check("pre_itr_isr", rd, 32'h0);
        axi_write(5'h14, 32'h1, 4'hF, 1'b0);
        check("itr_irq_at_commit", 32'(irq_at_commit), 32'd0);
`ifdef PL_INTR_SWTRIG_EN
        check("itr_irq", 32'(irq), 32'd1);
        axi_read(5'h08, rd); check("itr_isr", rd, 32'h1);
`else
        check("itr_irq", 32'(irq), 32'd0);
        axi_read(5'h08, rd); check("itr_isr", rd, 32'h0);
`endif
        axi_read(5'h14, rd); check("itr_reads_zero", rd, 32'h0);

        // Reset in the middle of a read: no response survives
        @(negedge clk);
        axi.S_AXI_ARADDR  = 5'h00;
        axi.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        axi.S_AXI_ARVALID = 1'b0;
        check("abort_rvalid_pre", 32'(axi.S_AXI_RVALID), 32'd1);
        ARESET = 1'b1;
        #1;
        check("abort_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
        check("abort_rdata",  axi.S_AXI_RDATA,       32'd0);
        check("abort_irq",    32'(irq),              32'd0);
        @(negedge clk);
        ARESET = 1'b0;
        @(negedge clk);
        check("abort_rvalid_post", 32'(axi.S_AXI_RVALID), 32'd0);
        axi_read(5'h00, rd); check("abort_gie", rd, 32'h0);
        axi_read(5'h08, rd); check("abort_isr", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
